async_fifo_rd_drain: RTL and testbench
======================================

Name: async_fifo_rd_drain

Overview:
- Read-side consumer for the team's asynchronous FIFO; sits entirely in the read clock domain.
- Issues r_en to the FIFO whenever data is available and downstream space exists, captures data_out one cycle later, and re-presents words on a valid/ready stream.
- A 2-entry skid buffer absorbs backpressure, so sustained throughput is 1 word/cycle.
- An enable/flush FSM allows clean stop without losing in-flight words.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
CNT_W, 16, width of the delivered-word counter.

Ports:
r_clk  input  1  read-domain clock; all logic on posedge.
r_rst  input  1  asynchronous, active-low reset.
enable  input  1  level; 1 = drain FIFO, 0 = stop issuing reads and flush.
empty  input  1  FIFO empty flag, already synchronous to r_clk.
r_en  output  1  FIFO read strobe; combinational from registered state, empty and m_ready.
data_out  input  WIDTH  FIFO read data; valid the cycle after r_en was sampled high.
m_valid  output  1  downstream word valid (registered).
m_data  output  WIDTH  downstream word, head of skid buffer (registered).
m_ready  input  1  downstream accept.
busy  output  1  1 while state != IDLE (registered).
rd_count  output  CNT_W  total words accepted downstream (see Optional Feature).

Behaviour:
Reset:
- On r_rst=0, asynchronously: state=IDLE, r_en=0, m_valid=0, m_data=0, busy=0, rd_count=0.
- Skid buffer count buf_cnt=0; pending flag pend=0.
- Reset mid-operation discards buffered and in-flight words; any word the FIFO returns afterwards is ignored.

Internal bookkeeping:
- buf_cnt is 0..2; pend=1 means a word is due on data_out this cycle.
- pop = m_valid & m_ready.

FSM:
- IDLE: r_en=0. enable=1 -> ACTIVE.
- ACTIVE: r_en = !empty & ((buf_cnt + pend - pop) < 2). enable=0 -> FLUSH.
- FLUSH: r_en=0; deliver remaining words. When buf_cnt==0 & pend==0 -> IDLE. enable=1 while in FLUSH -> ACTIVE directly.

Datapath and timing:
- r_en=1 at edge n sets pend at n+1; data_out is captured into the skid buffer at that edge.
- Read-to-m_valid latency is 2 cycles from r_en.
- Simultaneous capture and pop keeps buf_cnt unchanged; FIFO order is preserved.
- m_valid = (buf_cnt != 0). m_data is stable while m_valid=1 and m_ready=0.
- Credit rule guarantees buf_cnt never exceeds 2. Overflow is a design error; the bench asserts against it.

Boundaries:
- empty=1: no r_en, even if space exists.
- m_ready held 0: reads stop after the buffer plus pending reach 2.
- When empty deasserts and reasserts on consecutive cycles, r_en follows empty with no hysteresis.

Optional Feature:
Macro: ASYNC_FIFO_RD_CNT_EN
- Defined: rd_count increments by 1 on every pop and wraps from 2^CNT_W-1 to 0. It holds its value through FLUSH/IDLE and is cleared only by reset.
- Not defined: rd_count is tied to 0 and the counter logic is absent; the port list is unchanged.

Test Plan:
1. Reset, enable=1, FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> r_en high 3 consecutive cycles; m_valid high 3 cycles from 2 cycles after the first r_en; m_data 0x11,0x22,0x33; rd_count=3 (macro on).
2. 8 words queued, m_ready=0 -> exactly 2 r_en pulses; m_valid=1 with m_data frozen at word0; then m_ready=1 -> remaining 6 words read, all 8 delivered in order with no gaps after restart.
3. Streaming with enable dropped mid-burst while pend=1 -> FSM enters FLUSH; no further r_en; in-flight and buffered words delivered; busy falls 1 cycle after the last pop.
4. empty held 1 with enable=1 -> r_en stays 0, m_valid stays 0, busy=1; empty falls -> first r_en the same cycle.
5. r_rst asserted while buf_cnt=2 -> m_valid=0, m_data=0, busy=0, rd_count=0 immediately; after release, no stale word appears.
6. CNT_W=4 with macro on, 17 words popped -> rd_count reads 1 (wrap); with macro off -> rd_count always 0.

Source files
------------

// File: rtl/async_fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_drain
//
// Read-side consumer for the asynchronous FIFO. Lives entirely in the read
// clock domain. It strobes r_en whenever the FIFO has data and there is
// room downstream, captures data_out the cycle after each strobe, and
// re-presents the words on a valid/ready stream through a 2-entry skid
// buffer, so a stalled consumer never loses a word and a flowing one sees
// one word per cycle.
//
// An enable/flush FSM stops new reads when enable drops while still
// delivering every word that is already buffered or in flight.
//
// Optional feature: define ASYNC_FIFO_RD_CNT_EN to build the delivered-word
// counter behind rd_count. Without it rd_count is tied to zero and the
// counter is not built; the port list is the same either way.
//
// Parameters:
//   WIDTH    data word width (must match the FIFO)
//   CNT_W    width of the delivered-word counter
//
// Ports:
//   r_clk     read-domain clock, all logic on posedge
//   r_rst     asynchronous active-low reset
//   enable    1 = drain the FIFO, 0 = stop issuing reads and flush
//   empty     FIFO empty flag, synchronous to r_clk
//   r_en      FIFO read strobe (combinational from state, empty, m_ready)
//   data_out  FIFO read data, valid the cycle after r_en was sampled
//   m_valid   downstream word valid (registered)
//   m_data    downstream word, head of the skid buffer (registered)
//   m_ready   downstream accept
//   busy      1 while the FSM is not IDLE (registered)
//   rd_count  words accepted downstream, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module async_fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             enable,
  input  logic             empty,
  output logic             r_en,
  input  logic [WIDTH-1:0] data_out,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Skid buffer: head is what the consumer sees (m_data), tail holds the
  // second word when the consumer stalls.
  logic [1:0]       buf_cnt;
  logic [1:0]       buf_cnt_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_nxt;

  // pend: a read was issued last cycle, so data_out carries a word now.
  logic             pend;
  logic             pop;
  logic             cap;
  logic [2:0]       occ;

  // Occupancy the buffer will have once this cycle's capture and pop have
  // settled. A new read is only safe when that stays below two, because
  // the word it fetches lands one cycle later with no way to refuse it.
  function automatic logic [2:0] occupancy(input logic [1:0] cnt,
                                           input logic       in_flight,
                                           input logic       leaving);
    occupancy = {1'b0, cnt} + {2'b00, in_flight} - {2'b00, leaving};
  endfunction

  always_comb begin
    pop = m_valid & m_ready;
    cap = pend;
    occ = occupancy(buf_cnt, pend, pop);
  end

  // -------------------------------------------------------------------------
  // Control: enable/flush FSM and read strobe
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        // empty is used as-is each cycle so r_en tracks it without lag.
        r_en = !empty && (occ < 3'd2);
        if (!enable) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // No new reads; stay until the in-flight word and buffer drain,
        // unless the consumer is re-enabled first.
        if (enable) begin
          state_nxt = ACTIVE;
        end else if ((buf_cnt == 2'd0) && !pend) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Skid buffer next state. Capture appends behind existing words and pop
  // removes the head, so FIFO order is preserved in every combination.
  // -------------------------------------------------------------------------
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    head_nxt    = m_data;
    tail_nxt    = tail;
    case ({cap, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) begin
          head_nxt = data_out;
        end else begin
          tail_nxt = data_out;
        end
        buf_cnt_nxt = buf_cnt + 2'd1;
      end
      2'b01: begin
        head_nxt    = tail;
        buf_cnt_nxt = buf_cnt - 2'd1;
      end
      2'b11: begin
        // One in, one out: count unchanged, queue shifts forward.
        if (buf_cnt == 2'd1) begin
          head_nxt = data_out;
        end else begin
          head_nxt = tail;
          tail_nxt = data_out;
        end
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered stage: state, in-flight flag, buffer head and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state   <= IDLE;
      pend    <= 1'b0;
      buf_cnt <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Clearing pend on reset drops any word the FIFO still returns.
      pend    <= r_en;
      buf_cnt <= buf_cnt_nxt;
      m_valid <= (buf_cnt_nxt != 2'd0);
      m_data  <= head_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  // Second skid slot is only meaningful while buf_cnt == 2, so it needs no
  // reset value.
  always_ff @(posedge r_clk) begin
    tail <= tail_nxt;
  end

  // -------------------------------------------------------------------------
  // Delivered-word counter
  // -------------------------------------------------------------------------
`ifdef ASYNC_FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Free-running wrap; holds through FLUSH/IDLE, cleared only by reset.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_rd_drain
//
// Directed bench for async_fifo_rd_drain. A queue models the FIFO: a read
// strobe seen before an edge pops the queue onto data_out just after that
// edge, and empty follows the queue. Every cycle records r_en, m_valid and
// busy into per-window bit vectors and collects popped words so each step
// can compare against hand-derived patterns. CNT_W is 4 so the counter
// wrap is reachable.
// ---------------------------------------------------------------------------
module tb_async_fifo_rd_drain;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             r_clk = 1'b0;
  logic             r_rst;
  logic             enable;
  logic             empty;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic             busy;
  logic [CNT_W-1:0] rd_count;

  always #5 r_clk = ~r_clk;

  async_fifo_rd_drain #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .enable   (enable),
    .empty    (empty),
    .r_en     (r_en),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .busy     (busy),
    .rd_count (rd_count)
  );

  int               checks   = 0;
  int               failures = 0;
  logic [7:0]       fifo_q[$];
  logic [7:0]       got[$];
  logic             hold_empty;
  int               tot_pop;
  logic             re_s;
  logic             pop_s;
  logic             em_s;
  logic [7:0]       md_s;
  logic [15:0]      ren_v;
  logic [15:0]      mv_v;
  logic [15:0]      busy_v;
  int               widx;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag, input int idx,
                         input logic [7:0] exp);
    logic [31:0] obs;
    obs = (idx < got.size()) ? {24'd0, got[idx]} : 32'hDEAD_BEEF;
    chk(tag, obs, {24'd0, exp});
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef ASYNC_FIFO_RD_CNT_EN
    return CNT_W'(tot_pop);
`else
    return '0;
`endif
  endfunction

  task automatic win_clear();
    ren_v  = '0;
    mv_v   = '0;
    busy_v = '0;
    widx   = 0;
    got.delete();
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
    end
    empty = hold_empty || (fifo_q.size() == 0);
  endtask

  // One clock: sample mid-cycle, take the edge, then update the FIFO model.
  task automatic cyc();
    #3;
    re_s  = r_en;
    em_s  = empty;
    pop_s = m_valid & m_ready;
    md_s  = m_data;
    if (widx < 16) begin
      ren_v[widx]  = re_s;
      mv_v[widx]   = m_valid;
      busy_v[widx] = busy;
    end
    widx++;
    @(posedge r_clk);
    #1;
    if (pop_s) begin
      got.push_back(md_s);
      tot_pop++;
    end
    if (re_s && (fifo_q.size() > 0)) begin
      data_out = fifo_q.pop_front();
    end
    empty = hold_empty || (fifo_q.size() == 0);
    chk("ren_while_empty", {31'd0, re_s & em_s}, 32'd0);
    chk("buf_overflow", (dut.buf_cnt == 2'd3) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    r_rst      = 1'b0;
    enable     = 1'b0;
    empty      = 1'b1;
    m_ready    = 1'b0;
    data_out   = '0;
    hold_empty = 1'b0;
    tot_pop    = 0;
    win_clear();

    // Reset state
    repeat (2) @(posedge r_clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("rst_r_en", {31'd0, r_en}, 32'd0);
    r_rst = 1'b1;

    // Three preloaded words, consumer always ready
    enable  = 1'b1;
    m_ready = 1'b1;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    empty = 1'b0;
    win_clear();
    repeat (8) cyc();
    chk("t1_ren_pattern", {24'd0, ren_v[7:0]}, 32'h0E);
    chk("t1_mvalid_pattern", {24'd0, mv_v[7:0]}, 32'h38);
    chk("t1_count", got.size(), 32'd3);
    chk_got("t1_word0", 0, 8'h11);
    chk_got("t1_word1", 1, 8'h22);
    chk_got("t1_word2", 2, 8'h33);
    chk("t1_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt()});
`ifdef ASYNC_FIFO_RD_CNT_EN
    chk("t1_rd_count_abs", {28'd0, rd_count}, 32'd3);
`else
    chk("t1_rd_count_abs", {28'd0, rd_count}, 32'd0);
`endif
    chk("t1_busy", {31'd0, busy}, 32'd1);

    // Eight words with consumer stalled, then released
    m_ready = 1'b0;
    win_clear();
    load(8'hA0, 8);
    repeat (6) cyc();
    chk("t2_stall_ren", {26'd0, ren_v[5:0]}, 32'h03);
    chk("t2_stall_mvalid", {26'd0, mv_v[5:0]}, 32'h3C);
    chk("t2_frozen_valid", {31'd0, m_valid}, 32'd1);
    chk("t2_frozen_data", {24'd0, m_data}, 32'hA0);
    m_ready = 1'b1;
    win_clear();
    repeat (12) cyc();
    chk("t2_restart_ren", {20'd0, ren_v[11:0]}, 32'h03F);
    chk("t2_restart_mvalid", {20'd0, mv_v[11:0]}, 32'h0FF);
    chk("t2_count", got.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk_got("t2_word", i, 8'hA0 + 8'(i));
    end
    chk("t2_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt()});

    // Enable dropped while a read is in flight
    win_clear();
    load(8'hB0, 6);
    cyc();
    enable = 1'b0;
    repeat (9) cyc();
    chk("t3_ren", {22'd0, ren_v[9:0]}, 32'h003);
    chk("t3_mvalid", {22'd0, mv_v[9:0]}, 32'h00C);
    chk("t3_busy", {22'd0, busy_v[9:0]}, 32'h01F);
    chk("t3_count", got.size(), 32'd2);
    chk_got("t3_word0", 0, 8'hB0);
    chk_got("t3_word1", 1, 8'hB1);
    fifo_q.delete();
    empty = 1'b1;

    // Enabled but FIFO empty; then empty toggling
    enable = 1'b1;
    win_clear();
    repeat (6) cyc();
    chk("t4_ren_idle", {26'd0, ren_v[5:0]}, 32'h00);
    chk("t4_mvalid_idle", {26'd0, mv_v[5:0]}, 32'h00);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    load(8'hC0, 3);
    cyc();
    chk("t4_ren_on_data", {31'd0, re_s}, 32'd1);
    hold_empty = 1'b1;
    empty      = 1'b1;
    cyc();
    chk("t4_ren_on_empty", {31'd0, re_s}, 32'd0);
    hold_empty = 1'b0;
    empty      = (fifo_q.size() == 0);
    cyc();
    chk("t4_ren_reopen", {31'd0, re_s}, 32'd1);
    repeat (6) cyc();
    chk("t4_count", got.size(), 32'd3);
    chk_got("t4_word0", 0, 8'hC0);
    chk_got("t4_word2", 2, 8'hC2);

    // Reset with the skid buffer full
    m_ready = 1'b0;
    win_clear();
    load(8'hD0, 4);
    repeat (3) cyc();
    chk("t5_full_valid", {31'd0, m_valid}, 32'd1);
    r_rst = 1'b0;
    #1;
    tot_pop = 0;
    chk("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("t5_rst_r_en", {31'd0, r_en}, 32'd0);
    repeat (2) cyc();
    r_rst   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b1;
    win_clear();
    repeat (4) cyc();
    chk("t5_no_stale", {28'd0, mv_v[3:0]}, 32'h0);
    chk("t5_no_pop", got.size(), 32'd0);

    // 17 pops since reset: counter wraps to 1 with CNT_W = 4
    win_clear();
    load(8'hE0, 15);
    enable = 1'b1;
    for (int i = 0; i < 60 && tot_pop < 17; i++) begin
      cyc();
    end
    chk("t6_all_popped", tot_pop, 32'd17);
    chk_got("t6_first", 0, 8'hD2);
    chk_got("t6_last", 16, 8'hEE);
    chk("t6_rd_count", {28'd0, rd_count}, {28'd0, exp_cnt()});
`ifdef ASYNC_FIFO_RD_CNT_EN
    chk("t6_wrap_abs", {28'd0, rd_count}, 32'd1);
`else
    chk("t6_wrap_abs", {28'd0, rd_count}, 32'd0);
`endif
    enable = 1'b0;
    repeat (4) cyc();
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_hold_count", {28'd0, rd_count}, {28'd0, exp_cnt()});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
